// File: rtl/wgt_resp_pkg.sv
// Shared widths, latency, error indices and return-flag type for the weight read responder.
package wgt_resp_pkg;

   localparam int ARRAY_N          = 16;
   localparam int MEM_ADDR_WIDTH_W = 48;
   localparam int SRAM_ADDR_W      = 12;
   localparam int WGT_DATA_W       = 128;
   localparam int SRAM_LATENCY     = 2;
   localparam int FIFO_DEPTH       = 4;
   localparam int CNT_W            = 8;

   localparam int ERR_RANGE = 0;
   localparam int ERR_DROP  = 1;

   typedef struct packed {
      logic valid;
      logic zero_sub;
   } ret_flag_t;

   // Any set bit above the SRAM address field means the row does not exist.
   function automatic logic addr_out_of_range(input logic [MEM_ADDR_WIDTH_W-1:0] addr);
      return |addr[MEM_ADDR_WIDTH_W-1:SRAM_ADDR_W];
   endfunction

endpackage

// File: rtl/wgt_read_responder_if.sv
// Request channel from the address generator plus the row stream to the array weight loader.
interface wgt_read_responder_if;
   import wgt_resp_pkg::*;

   logic                        mem_read_req;
   logic [MEM_ADDR_WIDTH_W-1:0] mem_read_addr;
   logic                        mem_read_ready;
   logic                        wgt_valid;
   logic [WGT_DATA_W-1:0]       wgt_data;
   logic [CNT_W-1:0]            wgt_row_idx;
   logic                        wgt_ready;

   modport master (
      output mem_read_req, mem_read_addr, wgt_ready,
      input  mem_read_ready, wgt_valid, wgt_data, wgt_row_idx
   );

   modport slave (
      input  mem_read_req, mem_read_addr, wgt_ready,
      output mem_read_ready, wgt_valid, wgt_data, wgt_row_idx
   );

endinterface

// File: rtl/wgt_resp_chk.sv
// Invariant checks for the responder's return path.
module wgt_resp_chk (
   input logic clk,
   input logic reset_n,
   input logic push,
   input logic full
);

   // Credits must keep a slot free for every read in flight.
   always @(posedge clk) begin
      if (reset_n) begin
         assert (!(push && full)) else $error("return buffer pushed while full");
      end
   end

endmodule

// File: rtl/wgt_resp_fifo.sv
// Show-ahead return buffer: head entry is visible whenever the buffer is not empty.
module wgt_resp_fifo #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic              do_push_s;
   logic              do_pop_s;

   assign full      = (count_r == (PTR_W+1)'(DEPTH));
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign head      = mem_r[rd_ptr_r];
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/wgt_read_responder.sv
// Accepts weight-row read beats, reads the weight SRAM, buffers returned rows and
// streams them to the array with a per-tile row index, tile_done pulse and sticky errors.
module wgt_read_responder
   import wgt_resp_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   wgt_read_responder_if.slave    bus,
   output logic                   sram_rd_en,
   output logic [SRAM_ADDR_W-1:0] sram_rd_addr,
   input  logic [WGT_DATA_W-1:0]  sram_rd_data,
   output logic                   tile_done,
   output logic                   busy,
   output logic [1:0]             err,
   input  logic                   err_clr
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CRED_W = PTR_W + 2;

   ret_flag_t             pipe_r [SRAM_LATENCY];
   ret_flag_t             exit_s;
   logic [CNT_W-1:0]      row_cnt_r;
   logic                  tile_done_r;
   logic [1:0]            err_r;
   logic [1:0]            err_set_s;
   logic [CRED_W-1:0]     inflight_s;
   logic [CRED_W-1:0]     credit_s;
   logic [PTR_W:0]        count_s;
   logic                  accept_s;
   logic                  range_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  full_s;
   logic                  empty_s;
   logic [WGT_DATA_W-1:0] push_data_s;
   logic [WGT_DATA_W-1:0] head_s;

   // Reads still travelling through the SRAM latency window.
   always_comb begin
      inflight_s = '0;
      for (int i = 0; i < SRAM_LATENCY; i++) begin
         inflight_s = inflight_s + CRED_W'(pipe_r[i].valid);
      end
   end

   // Ready depends only on registered occupancy so it never loops back from mem_read_req.
   assign credit_s           = CRED_W'(count_s) + inflight_s;
   assign bus.mem_read_ready = (credit_s < CRED_W'(FIFO_DEPTH));
   assign accept_s           = bus.mem_read_req & bus.mem_read_ready;
   assign range_s            = addr_out_of_range(bus.mem_read_addr);
   assign sram_rd_en         = accept_s;
   assign sram_rd_addr       = bus.mem_read_addr[SRAM_ADDR_W-1:0];

   assign exit_s      = pipe_r[SRAM_LATENCY-1];
   assign push_s      = exit_s.valid;
   assign push_data_s = exit_s.zero_sub ? {WGT_DATA_W{1'b0}} : sram_rd_data;
   assign pop_s       = bus.wgt_valid & bus.wgt_ready;

   // Error sources observed this cycle.
   always_comb begin
      err_set_s            = 2'b00;
      err_set_s[ERR_RANGE] = accept_s & range_s;
      err_set_s[ERR_DROP]  = bus.mem_read_req & ~bus.mem_read_ready;
   end

   // Return-flag shift tracking each issued read until its data is valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SRAM_LATENCY; i++) begin
            pipe_r[i] <= '0;
         end
      end else begin
         pipe_r[0] <= '{valid: accept_s, zero_sub: accept_s & range_s};
         for (int i = 1; i < SRAM_LATENCY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   // Row index within the tile and the end-of-tile pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_cnt_r   <= '0;
         tile_done_r <= 1'b0;
      end else begin
         tile_done_r <= 1'b0;
         if (pop_s) begin
            if (row_cnt_r == CNT_W'(ARRAY_N-1)) begin
               row_cnt_r   <= '0;
               tile_done_r <= 1'b1;
            end else begin
               row_cnt_r <= row_cnt_r + CNT_W'(1);
            end
         end
      end
   end

   // Sticky errors; a new event in the clearing cycle survives the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_r <= 2'b00;
      end else begin
         err_r <= (err_clr ? 2'b00 : err_r) | err_set_s;
      end
   end

   wgt_resp_fifo #(
      .DATA_W (WGT_DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (head_s),
      .count     (count_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   wgt_resp_chk u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .full    (full_s)
   );

   assign bus.wgt_valid   = ~empty_s;
   assign bus.wgt_data    = head_s;
   assign bus.wgt_row_idx = row_cnt_r;
   assign tile_done       = tile_done_r;
   assign err             = err_r;
   assign busy            = ~empty_s | (inflight_s != '0) | (row_cnt_r != '0);

endmodule
